// File: rtl/pattern_detector.sv
// pattern_detector: receive-side checker for a byte-serial 32-bit reference
// pattern (MSB byte first). Raises a one-cycle `detected` pulse once the
// pattern has been received back-to-back `n_repeats` times.
//
// Optional feature macro: PATTERN_DETECTOR_ERRCNT_EN
//   defined     -> err_count register counts mismatched bytes seen in MATCH
//   not defined -> err_count is tied to 0
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   data_valid    in   data_in carries a byte this cycle
//   data_in       in   [7:0]  received byte
//   pattern_in    in   [31:0] reference pattern, byte 0 = [31:24]
//   n_repeats     in   [7:0]  full-pattern matches required, 0 disables
//   detected      out  one-cycle pulse when a run completes
//   busy          out  high while in MATCH
//   rep_count     out  [7:0] full patterns matched in the current run
//   detect_count  out  [CNT_W-1:0] completed runs, saturating
//   err_count     out  [CNT_W-1:0] in-run mismatched bytes, saturating
module pattern_detector #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  input  logic [31:0]      pattern_in,
  input  logic [7:0]       n_repeats,
  output logic             detected,
  output logic             busy,
  output logic [7:0]       rep_count,
  output logic [CNT_W-1:0] detect_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    MATCH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  byte_idx_q;
  logic [1:0]  byte_idx_d;
  logic [31:0] pat_q;
  logic [7:0]  n_q;
  logic [7:0]  rep_d;
  logic        det_d;
  logic        capture_c;
  logic        det_inc_c;
  logic        err_inc_c;

  // Expected byte of the latched pattern at the current position.
  logic [7:0] exp_byte_c;
  always_comb begin
    exp_byte_c = pat_q[31:24];
    case (byte_idx_q)
      2'd0: exp_byte_c = pat_q[31:24];
      2'd1: exp_byte_c = pat_q[23:16];
      2'd2: exp_byte_c = pat_q[15:8];
      2'd3: exp_byte_c = pat_q[7:0];
      default: exp_byte_c = pat_q[31:24];
    endcase
  end

  logic       head_c;
  logic       resync_c;
  logic       hit_c;
  logic       enable_c;
  logic [7:0] rep_inc_c;
  logic       run_done_c;

  // IDLE compares against the live pattern; MATCH uses the latched copy.
  assign head_c     = (data_in == pattern_in[31:24]);
  assign resync_c   = (data_in == pat_q[31:24]);
  assign hit_c      = (data_in == exp_byte_c);
  assign enable_c   = (n_repeats != 8'd0);
  // rep_count < n_q inside a run, so the increment cannot wrap.
  assign rep_inc_c  = 8'(rep_count + 8'd1);
  assign run_done_c = (byte_idx_q == 2'd3) && (rep_inc_c == n_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; only valid bytes advance the machine.
  always_comb begin
    state_d = state_q;
    if (data_valid) begin
      case (state_q)
        IDLE: begin
          if (head_c && enable_c) begin
            state_d = MATCH;
          end
        end
        MATCH: begin
          if (hit_c) begin
            if (run_done_c) begin
              state_d = IDLE;
            end
          end else if (!resync_c) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    byte_idx_d = byte_idx_q;
    rep_d      = rep_count;
    det_d      = 1'b0;
    capture_c  = 1'b0;
    det_inc_c  = 1'b0;
    err_inc_c  = 1'b0;
    if (data_valid) begin
      case (state_q)
        IDLE: begin
          if (head_c && enable_c) begin
            capture_c  = 1'b1;
            byte_idx_d = 2'd1;
            rep_d      = 8'd0;
          end
        end
        MATCH: begin
          if (hit_c) begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_d = 2'(byte_idx_q + 2'd1);
            end else begin
              byte_idx_d = 2'd0;
              if (run_done_c) begin
                rep_d     = 8'd0;
                det_d     = 1'b1;
                det_inc_c = 1'b1;
              end else begin
                rep_d = rep_inc_c;
              end
            end
          end else begin
            // Single-byte resync only; no deeper overlap search.
            err_inc_c  = 1'b1;
            rep_d      = 8'd0;
            byte_idx_d = resync_c ? 2'd1 : 2'd0;
          end
        end
        default: begin
          byte_idx_d = 2'd0;
          rep_d      = 8'd0;
        end
      endcase
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q   <= 2'd0;
      rep_count    <= 8'd0;
      detected     <= 1'b0;
      busy         <= 1'b0;
      detect_count <= '0;
      pat_q        <= 32'd0;
      n_q          <= 8'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      rep_count  <= rep_d;
      detected   <= det_d;
      busy       <= (state_d == MATCH);
      if (det_inc_c && (detect_count != CNT_MAX)) begin
        detect_count <= CNT_W'(detect_count + CNT_W'(1));
      end
      if (capture_c) begin
        pat_q <= pattern_in;
        n_q   <= n_repeats;
      end
    end
  end

`ifdef PATTERN_DETECTOR_ERRCNT_EN
  // Saturating count of mismatches seen inside a run.
  logic [CNT_W-1:0] err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (err_inc_c && (err_q != CNT_MAX)) begin
      err_q <= CNT_W'(err_q + CNT_W'(1));
    end
  end
  assign err_count = err_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc_c;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed testbench for pattern_detector (CNT_W=2 so saturation is reachable).
module tb_pattern_detector;

  localparam int unsigned CNT_W = 2;

`ifdef PATTERN_DETECTOR_ERRCNT_EN
  localparam logic [31:0] ERR_ONE = 32'd1;
  localparam logic [31:0] ERR_TWO = 32'd2;
`else
  localparam logic [31:0] ERR_ONE = 32'd0;
  localparam logic [31:0] ERR_TWO = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             data_valid;
  logic [7:0]       data_in;
  logic [31:0]      pattern_in;
  logic [7:0]       n_repeats;
  logic             detected;
  logic             busy;
  logic [7:0]       rep_count;
  logic [CNT_W-1:0] detect_count;
  logic [CNT_W-1:0] err_count;

  int total = 0;
  int bad   = 0;

  pattern_detector #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .pattern_in   (pattern_in),
    .n_repeats    (n_repeats),
    .detected     (detected),
    .busy         (busy),
    .rep_count    (rep_count),
    .detect_count (detect_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one valid byte, then sample 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = 8'h00;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat_bytes [4];

  initial begin
    pat_bytes[0] = 8'hDE;
    pat_bytes[1] = 8'hAD;
    pat_bytes[2] = 8'hBE;
    pat_bytes[3] = 8'hEF;

    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    pattern_in = 32'hDEADBEEF;
    n_repeats  = 8'd2;
    #1;
    check("reset_detected", 32'(detected), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rep", 32'(rep_count), 32'd0);
    check("reset_dcnt", 32'(detect_count), 32'd0);
    check("reset_ecnt", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean 2-repeat run.
    send(8'hDE);
    check("t1_busy_start", 32'(busy), 32'd1);
    check("t1_rep_start", 32'(rep_count), 32'd0);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    check("t1_rep_one", 32'(rep_count), 32'd1);
    check("t1_no_det_mid", 32'(detected), 32'd0);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    check("t1_no_det_7", 32'(detected), 32'd0);
    send(8'hEF);
    check("t1_det", 32'(detected), 32'd1);
    check("t1_dcnt", 32'(detect_count), 32'd1);
    check("t1_rep_clr", 32'(rep_count), 32'd0);
    check("t1_busy_clr", 32'(busy), 32'd0);
    idle();
    check("t1_pulse_one_cycle", 32'(detected), 32'd0);

    // Mismatch that is not a resync byte drops back to IDLE.
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    send(8'hDE);
    send(8'hAD);
    send(8'h00);
    check("t2_no_det", 32'(detected), 32'd0);
    check("t2_rep", 32'(rep_count), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_ecnt", 32'(err_count), ERR_ONE);
    check("t2_dcnt", 32'(detect_count), 32'd1);
    idle();

    // Mismatch on DE resyncs to byte 1.
    send(8'hDE);
    send(8'hAD);
    send(8'hDE);
    check("t3_resync_busy", 32'(busy), 32'd1);
    check("t3_resync_rep", 32'(rep_count), 32'd0);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    check("t3_rep_one", 32'(rep_count), 32'd1);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    check("t3_det", 32'(detected), 32'd1);
    check("t3_dcnt", 32'(detect_count), 32'd2);
    check("t3_ecnt", 32'(err_count), ERR_TWO);
    idle();

    // n_repeats = 0 disables detection.
    n_repeats = 8'd0;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 4; k++) begin
        send(pat_bytes[k]);
        check("t4_no_det", 32'(detected), 32'd0);
        check("t4_no_busy", 32'(busy), 32'd0);
      end
    end
    idle();
    check("t4_dcnt", 32'(detect_count), 32'd2);

    // Gapped valid, pattern_in changed mid-run; latched pattern must be used.
    n_repeats = 8'd3;
    for (int i = 0; i < 12; i++) begin
      send(pat_bytes[i % 4]);
      if (i == 0) begin
        pattern_in = 32'h12345678;
        n_repeats  = 8'd1;
      end
      check("t5_det", 32'(detected), (i == 11) ? 32'd1 : 32'd0);
      idle();
      check("t5_gap_no_det", 32'(detected), 32'd0);
    end
    check("t5_dcnt", 32'(detect_count), 32'd3);
    check("t5_rep", 32'(rep_count), 32'd0);

    // n_repeats = 1, back-to-back runs; detect_count saturates at 3.
    pattern_in = 32'hDEADBEEF;
    n_repeats  = 8'd1;
    for (int i = 0; i < 8; i++) begin
      send(pat_bytes[i % 4]);
      check("t6_det", 32'(detected), ((i % 4) == 3) ? 32'd1 : 32'd0);
      if (i == 4) begin
        check("t6_busy_b2b", 32'(busy), 32'd1);
      end
    end
    check("t6_dcnt_sat", 32'(detect_count), 32'd3);
    idle();

    // Reset mid-run discards the run.
    n_repeats = 8'd2;
    for (int i = 0; i < 6; i++) begin
      send(pat_bytes[i % 4]);
    end
    check("t7_rep_before_rst", 32'(rep_count), 32'd1);
    @(negedge clk);
    data_valid = 1'b0;
    rst        = 1'b1;
    #1;
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_rep", 32'(rep_count), 32'd0);
    check("t7_rst_dcnt", 32'(detect_count), 32'd0);
    check("t7_rst_ecnt", 32'(err_count), 32'd0);
    check("t7_rst_det", 32'(detected), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(pat_bytes[i % 4]);
      check("t7_det", 32'(detected), (i == 7) ? 32'd1 : 32'd0);
    end
    check("t7_dcnt", 32'(detect_count), 32'd1);
    idle();
    check("t7_det_end", 32'(detected), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
